// File: rtl/argmax_classifier_pkg.sv
// Shared definitions for the argmax classifier stage: build switch,
// FSM state encoding and the network's default layer dimensions.
package pa_argmax_classifier;

  // 1 = classifier logic present, 0 = empty shell with outputs tied low
  localparam bit INCLUDE_ARGMAX_CLASSIFIER = 1'b1;

  // Output-layer dimensions shared with the network top
  localparam int DATA_WIDTH  = 8;
  localparam int NS_IN_LAYER = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : pa_argmax_classifier

// File: rtl/argmax_classifier_compare_cell.sv
// One step of the running argmax: compares a candidate activation against the
// current best and produces the updated best value/index and tie flag.
module argmax_compare_cell #(
  parameter int DataWidth = 8,
  parameter int IdxWidth  = 4
) (
  input  logic [DataWidth-1:0] cand_val,
  input  logic [IdxWidth-1:0]  cand_idx,
  input  logic [DataWidth-1:0] best_val,
  input  logic [IdxWidth-1:0]  best_idx,
  input  logic                 best_tie,
  output logic [DataWidth-1:0] new_val,
  output logic [IdxWidth-1:0]  new_idx,
  output logic                 new_tie
);

  // Strictly greater replaces the best and clears the tie; equal keeps the
  // lower (earlier) index and only flags the tie.
  always_comb begin
    new_val = best_val;
    new_idx = best_idx;
    new_tie = best_tie;
    if (cand_val > best_val) begin
      new_val = cand_val;
      new_idx = cand_idx;
      new_tie = 1'b0;
    end else if (cand_val == best_val) begin
      new_tie = 1'b1;
    end
  end

endmodule : argmax_compare_cell

// File: rtl/argmax_classifier.sv
// Argmax over the output-layer activations: snapshots the vector on start,
// scans one neuron per cycle and publishes index/value/tie with a done pulse.
module argmax_classifier #(
  parameter bit INCLUDE_ARGMAX_CLASSIFIER = pa_argmax_classifier::INCLUDE_ARGMAX_CLASSIFIER,
  parameter int dataWidth = pa_argmax_classifier::DATA_WIDTH,
  parameter int NsInLayer = pa_argmax_classifier::NS_IN_LAYER,
  parameter int IdxWidth  = (NsInLayer > 1) ? $clog2(NsInLayer) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NsInLayer-1:0][dataWidth-1:0] inputActivation,
  output logic                                busy,
  output logic                                done,
  output logic [IdxWidth-1:0]                 classIdx,
  output logic [dataWidth-1:0]                maxValue,
  output logic                                tie
);

  import pa_argmax_classifier::*;

  if (INCLUDE_ARGMAX_CLASSIFIER) begin : g_core

    state_t                              state_q, state_d;
    logic [NsInLayer-1:0][dataWidth-1:0] snap_q, snap_d;
    logic [dataWidth-1:0]                best_val_q, best_val_d;
    logic [IdxWidth-1:0]                 best_idx_q, best_idx_d;
    logic                                tie_w_q, tie_w_d;
    logic [IdxWidth-1:0]                 cnt_q, cnt_d;
    logic [IdxWidth-1:0]                 class_idx_q, class_idx_d;
    logic [dataWidth-1:0]                max_value_q, max_value_d;
    logic                                tie_q, tie_d;

    logic [dataWidth-1:0]                cmp_val;
    logic [IdxWidth-1:0]                 cmp_idx;
    logic                                cmp_tie;

    argmax_compare_cell #(
      .DataWidth (dataWidth),
      .IdxWidth  (IdxWidth)
    ) u_cmp (
      .cand_val (snap_q[cnt_q]),
      .cand_idx (cnt_q),
      .best_val (best_val_q),
      .best_idx (best_idx_q),
      .best_tie (tie_w_q),
      .new_val  (cmp_val),
      .new_idx  (cmp_idx),
      .new_tie  (cmp_tie)
    );

    // Next-state and datapath: capture in IDLE/DONE, one compare per SCAN cycle,
    // results published on the edge that enters DONE.
    always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      tie_w_d     = tie_w_q;
      cnt_d       = cnt_q;
      class_idx_d = class_idx_q;
      max_value_d = max_value_q;
      tie_d       = tie_q;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            snap_d     = inputActivation;
            best_val_d = inputActivation[0];
            best_idx_d = '0;
            tie_w_d    = 1'b0;
            cnt_d      = IdxWidth'(1);
            if (NsInLayer == 1) begin
              // Single neuron: the snapshot is already the answer
              state_d     = DONE;
              class_idx_d = '0;
              max_value_d = inputActivation[0];
              tie_d       = 1'b0;
            end else begin
              state_d = SCAN;
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          best_val_d = cmp_val;
          best_idx_d = cmp_idx;
          tie_w_d    = cmp_tie;
          cnt_d      = cnt_q + IdxWidth'(1);
          if (cnt_q == IdxWidth'(NsInLayer - 1)) begin
            // Last neuron: publish the compare result directly so the
            // outputs reflect this final step too
            state_d     = DONE;
            class_idx_d = cmp_idx;
            max_value_d = cmp_val;
            tie_d       = cmp_tie;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // State and datapath registers; reset clears everything and aborts a scan
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q     <= IDLE;
        snap_q      <= '0;
        best_val_q  <= '0;
        best_idx_q  <= '0;
        tie_w_q     <= 1'b0;
        cnt_q       <= '0;
        class_idx_q <= '0;
        max_value_q <= '0;
        tie_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        snap_q      <= snap_d;
        best_val_q  <= best_val_d;
        best_idx_q  <= best_idx_d;
        tie_w_q     <= tie_w_d;
        cnt_q       <= cnt_d;
        class_idx_q <= class_idx_d;
        max_value_q <= max_value_d;
        tie_q       <= tie_d;
      end
    end

    assign busy     = (state_q == SCAN);
    assign done     = (state_q == DONE);
    assign classIdx = class_idx_q;
    assign maxValue = max_value_q;
    assign tie      = tie_q;

  end else begin : g_shell

    assign busy     = 1'b0;
    assign done     = 1'b0;
    assign classIdx = '0;
    assign maxValue = '0;
    assign tie      = 1'b0;

  end

endmodule : argmax_classifier
